aap_regfile_mp: RTL
===================

// Module: aap_regfile_mp
// PURPOSE
//  Parametrised multi-port register file; successor to the fixed 64x16, 3-read/2-write AAP file.
//  - Generic read/write port counts; registered reads; defined write-collision priority.
//  - Self-clearing sequencer after reset, with a ready flag.
//  - Sits between decode/execute and writeback. The execute stage gates its issue on ready.
// PARAMETERS
//  DATA_W  16  register width in bits
//  ADDR_W  6   register address width
//  DEPTH   64  number of registers (<= 2**ADDR_W)
//  NRD     3   number of read ports
//  NWR     2   number of write ports
// PORTS
//  clock       in   1            single clock; all state changes on posedge
//  reset       in   1            synchronous, active-high
//  rd_en       in   NRD          per-port read request
//  rd_addr     in   NRD*ADDR_W   read addresses; port j = [j*ADDR_W +: ADDR_W]
//  rd_data     out  NRD*DATA_W   registered read data; port j = [j*DATA_W +: DATA_W]
//  rd_valid    out  NRD          rd_data[j] was updated by the previous cycle's request
//  wr_en       in   NWR          per-port write enable
//  wr_addr     in   NWR*ADDR_W   write addresses
//  wr_data     in   NWR*DATA_W   write data
//  ready       out  1            1 = file cleared and accepting reads/writes
//  wr_collide  out  1            1-cycle pulse: >=2 enabled write ports hit the same address
// BEHAVIOUR
//  - Reset (reset=1 at posedge) forces the following, with no other state change that cycle:
//    - state=CLEAR, clr_ptr=0, ready=0;
//    - rd_data=0, rd_valid=0, wr_collide=0.
//  - FSM CLEAR:
//    - each cycle with reset=0: mem[clr_ptr]<=0, clr_ptr++;
//    - on the cycle writing DEPTH-1, go to RUN and set ready<=1;
//    - ready rises exactly DEPTH clocks after the first reset=0 edge.
//  - FSM RUN: stays in RUN until reset. Reset mid-RUN restarts CLEAR from 0 and drops in-flight reads.
//  - During CLEAR: wr_en and rd_en are ignored; rd_valid=0; wr_collide=0.
//  - Write (RUN), for each port i with wr_en[i]:
//    - mem[wr_addr_i]<=wr_data_i at posedge, zero latency to storage;
//    - addresses >= DEPTH are silently dropped.
//  - Write collision, two or more enabled ports with equal in-range address:
//    - the highest-index port wins;
//    - wr_collide=1 on the following cycle only.
//  - Read (RUN): 1-cycle latency.
//    - rd_en[j] at edge N -> rd_data_j = mem[rd_addr_j] and rd_valid[j]=1 after edge N+1... i.e. valid in cycle N+1.
//    - rd_en[j]=0: rd_data_j holds its last value and rd_valid[j]=0.
//    - Out-of-range read address returns 0 with rd_valid=1.
//  - Same-cycle read and write to the same address: see CONFIGURATION.
//  - Arithmetic: clr_ptr is ADDR_W+1 bits wide, so there is no wrap ambiguity when DEPTH=2**ADDR_W.
// CONFIGURATION
//  REGFILE_BYPASS_EN
//  - Defined: a read that coincides with an enabled in-range write to the same address returns the
//    new data. With several such writers, it returns the winning (highest-index) port's data.
//  - Undefined: a coinciding read returns the pre-write (old) contents. The new value is visible
//    from the next read.
// TESTING
//  1. Hold reset 2 cycles, release -> ready=0 for exactly 64 cycles, then 1.
//     Read all 64 addresses -> every rd_data=0x0000.
//  2. RUN: wr port0 addr 5 = 0xBEEF; next cycle rd_en[0..2] at 5 ->
//     one cycle later all three rd_data=0xBEEF, rd_valid=3'b111.
//  3. wr port0 addr 9 = 0x1111 and port1 addr 9 = 0x2222 in the same cycle ->
//     wr_collide=1 for one cycle; later read addr 9 = 0x2222.
//  4. mem[3]=0x00AA; same cycle write 3 = 0x0055 and read 3 ->
//     0x0055 with REGFILE_BYPASS_EN, 0x00AA without. Next read = 0x0055 in both builds.
//  5. Assert reset for 1 cycle mid-RUN while rd_en=1 ->
//     rd_valid=0 next cycle, ready=0 for 64 cycles, and a previously written addr reads 0 afterwards.
//  6. Parametrise DEPTH=40, ADDR_W=6: write addr 50 = 0xFFFF -> no change, no collide.
//     Read addr 50 -> 0 with rd_valid=1. ready rises after 40 cycles.

Source files
------------

// File: rtl/aap_regfile_mp.sv
// aap_regfile_mp: parametrised multi-port register file.
//   After reset a sequencer zeroes every register, one per cycle, and then
//   raises ready. Reads are registered (one cycle of latency). Writes go
//   straight into storage. When several write ports hit the same address,
//   the highest-index port wins.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   - a read that coincides with an in-range write to the same
//               address returns the winning write data.
//   undefined - a coinciding read returns the pre-write contents.
//
// Ports:
//   clock       single clock, posedge
//   reset       synchronous, active-high
//   rd_en       [NRD]          per-port read request
//   rd_addr     [NRD*ADDR_W]   read addresses, port j at [j*ADDR_W +: ADDR_W]
//   rd_data     [NRD*DATA_W]   registered read data, port j at [j*DATA_W +: DATA_W]
//   rd_valid    [NRD]          rd_data[j] updated by previous cycle's request
//   wr_en       [NWR]          per-port write enable
//   wr_addr     [NWR*ADDR_W]   write addresses
//   wr_data     [NWR*DATA_W]   write data
//   ready       file cleared and accepting traffic
//   wr_collide  one-cycle pulse: two or more enabled writers hit one address
module aap_regfile_mp #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned NRD    = 3,
    parameter int unsigned NWR    = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NRD-1:0]           rd_en,
    input  logic [NRD*ADDR_W-1:0]    rd_addr,
    output logic [NRD*DATA_W-1:0]    rd_data,
    output logic [NRD-1:0]           rd_valid,
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR*ADDR_W-1:0]    wr_addr,
    input  logic [NWR*DATA_W-1:0]    wr_data,
    output logic                     ready,
    output logic                     wr_collide
);

    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_LIM = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state;
    logic [PTR_W-1:0]  clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_next [NRD];
    logic              collide_c;

    // Addresses at or above DEPTH are dropped on write and read back as zero.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_LIM;
    endfunction

    // Any pair of enabled writers aimed at the same in-range address.
    always_comb begin
        collide_c = 1'b0;
        for (int unsigned i = 0; i < NWR; i++) begin
            for (int unsigned k = i + 1; k < NWR; k++) begin
                if (wr_en[i] && wr_en[k] &&
                    (wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[k*ADDR_W +: ADDR_W]) &&
                    in_range(wr_addr[i*ADDR_W +: ADDR_W])) begin
                    collide_c = 1'b1;
                end
            end
        end
    end

    // Next read data per port; ascending port scan lets the highest writer win.
    always_comb begin
        for (int unsigned j = 0; j < NRD; j++) begin
            rd_next[j] = in_range(rd_addr[j*ADDR_W +: ADDR_W])
                       ? mem[rd_addr[j*ADDR_W +: ADDR_W]] : '0;
`ifdef REGFILE_BYPASS_EN
            for (int unsigned i = 0; i < NWR; i++) begin
                if (wr_en[i] && in_range(wr_addr[i*ADDR_W +: ADDR_W]) &&
                    (wr_addr[i*ADDR_W +: ADDR_W] == rd_addr[j*ADDR_W +: ADDR_W])) begin
                    rd_next[j] = wr_data[i*DATA_W +: DATA_W];
                end
            end
`endif
        end
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_CLEAR;
            clr_ptr    <= '0;
            ready      <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= '0;
            wr_collide <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_ptr    <= clr_ptr + PTR_W'(1);
                    rd_valid   <= '0;
                    wr_collide <= 1'b0;
                    if (clr_ptr == LAST_PTR) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    wr_collide <= collide_c;
                    rd_valid   <= rd_en;
                    for (int unsigned j = 0; j < NRD; j++) begin
                        if (rd_en[j]) begin
                            rd_data[j*DATA_W +: DATA_W] <= rd_next[j];
                        end
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

    // Storage: zeroed by the sequencer, then written by the ports in RUN.
    // Reset itself leaves the contents untouched.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == ST_CLEAR) begin
                mem[clr_ptr[ADDR_W-1:0]] <= '0;
            end else begin
                for (int unsigned i = 0; i < NWR; i++) begin
                    if (wr_en[i] && in_range(wr_addr[i*ADDR_W +: ADDR_W])) begin
                        mem[wr_addr[i*ADDR_W +: ADDR_W]] <= wr_data[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

endmodule
